// File: rtl/inference_sequencer.sv
// Sequencer for the digit-recognition pipeline: clear, pool, dense1, dense2, argmax.
// Each stage runs under a watchdog; result, status and cycle count are registered.
//
// state  | meaning
// IDLE   | waiting for start
// CLR    | layer_rst held for CLR_CYCLES cycles
// POOL   | pooling enabled, waiting for pool_done
// DENSE1 | dense layer 1 enabled, waiting for dense1_done
// DENSE2 | dense layer 2 enabled, waiting for dense2_done
// ARGMAX | argmax enabled, digit latched on argmax_done
// DONE   | one cycle, publishes result_valid and perf_cycles
// ERR    | a stage timed out, waiting for start or abort
module inference_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CLR_CYCLES     = 2,
  parameter int PERF_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              layer_rst,
  output logic              pool_en,
  input  logic              pool_done,
  output logic              dense1_en,
  input  logic              dense1_done,
  output logic              dense2_en,
  input  logic              dense2_done,
  output logic              argmax_en,
  input  logic              argmax_done,
  input  logic [3:0]        digit_in,
  output logic [3:0]        result,
  output logic              result_valid,
  output logic              busy,
  output logic              error,
  output logic [2:0]        stage,
  output logic [PERF_W-1:0] perf_cycles
);

  localparam int MAXC = (TIMEOUT_CYCLES > CLR_CYCLES) ? TIMEOUT_CYCLES : CLR_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_POOL   = 3'd2,
    S_DENSE1 = 3'd3,
    S_DENSE2 = 3'd4,
    S_ARGMAX = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t            state, next_state;
  logic [CW-1:0]     step_cnt;
  logic [PERF_W-1:0] perf_cnt;
  logic              stage_done, timeout, abort_hit, in_run;
  logic              layer_rst_d, pool_en_d, dense1_en_d, dense2_en_d, argmax_en_d;
  logic              busy_d, error_d;

  always_comb begin
    stage_done = 1'b0;
    case (state)
      S_POOL:   stage_done = pool_done;
      S_DENSE1: stage_done = dense1_done;
      S_DENSE2: stage_done = dense2_done;
      S_ARGMAX: stage_done = argmax_done;
      default:  stage_done = 1'b0;
    endcase
  end

  assign timeout   = (step_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign abort_hit = abort && (state != S_IDLE);
  assign in_run    = (state >= S_CLR) && (state <= S_ARGMAX);
  assign stage     = state;

  always_comb begin
    next_state = state;
    if (abort_hit) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start && !abort) next_state = S_CLR;
        S_CLR:  if (step_cnt == CW'(CLR_CYCLES - 1)) next_state = S_POOL;
        S_POOL, S_DENSE1, S_DENSE2, S_ARGMAX: begin
          // done in the last watchdog cycle still advances normally
          if (stage_done)   next_state = state_t'(state + 3'd1);
          else if (timeout) next_state = S_ERR;
        end
        S_DONE: next_state = S_IDLE;
        S_ERR:  if (start) next_state = S_CLR;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // outputs are decoded from the next state and registered alongside it
  always_comb begin
    layer_rst_d = (next_state == S_CLR) || abort_hit;
    pool_en_d   = (next_state == S_POOL);
    dense1_en_d = (next_state == S_DENSE1);
    dense2_en_d = (next_state == S_DENSE2);
    argmax_en_d = (next_state == S_ARGMAX);
    busy_d      = (next_state != S_IDLE) && (next_state != S_ERR);
    error_d     = (next_state == S_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      step_cnt     <= '0;
      perf_cnt     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      perf_cycles  <= '0;
      layer_rst    <= 1'b0;
      pool_en      <= 1'b0;
      dense1_en    <= 1'b0;
      dense2_en    <= 1'b0;
      argmax_en    <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state     <= next_state;
      layer_rst <= layer_rst_d;
      pool_en   <= pool_en_d;
      dense1_en <= dense1_en_d;
      dense2_en <= dense2_en_d;
      argmax_en <= argmax_en_d;
      busy      <= busy_d;
      error     <= error_d;

      if (next_state != state) step_cnt <= '0;
      else if (in_run)         step_cnt <= step_cnt + 1'b1;

      if (next_state == S_CLR && state != S_CLR) perf_cnt <= '0;
      else if (in_run && perf_cnt != '1)         perf_cnt <= perf_cnt + 1'b1;

      if (state == S_ARGMAX && next_state == S_DONE) result <= digit_in;

      if (state == S_DONE && !abort_hit) begin
        result_valid <= 1'b1;
        perf_cycles  <= perf_cnt;
      end else if (next_state == S_CLR && state != S_CLR) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule
